lpr_char_scheduler: RTL and testbench
=====================================

// Module: lpr_char_scheduler
// PURPOSE
//  Frame-level scheduler that time-multiplexes NUM_ENG capture/recognition engine pairs over NUM_CHAR plate characters.
//  Snapshots the segmentation windows, hands one batch of NUM_ENG windows to the engines per frame, and collects each
//  engine's char code at the next frame boundary. Sits between character segmentation and the display/UART result path.
// PARAMETERS
//  NUM_CHAR   8   character slots per plate
//  NUM_ENG    2   recognition engines available; NUM_BATCH = ceil(NUM_CHAR/NUM_ENG)
//  CNT_W      12  pixel counter width
//  CHAR_W     40  recognised char code width
// PORTS
//  pixelclk      in   1                 pixel clock
//  reset_n       in   1                 reset, asynchronous, active-low
//  i_vs          in   1                 video vsync; rising edge = frame boundary
//  start         in   1                 1-cycle request to begin a recognition pass
//  abort         in   1                 level; forces return to IDLE
//  auto_rearm    in   1                 at pass end, immediately re-arm with fresh snapshot
//  seg_valid     in   1                 segmentation windows are valid
//  hcount_l_flat in   NUM_CHAR*CNT_W    left column per char, slot i at [i*CNT_W +: CNT_W]
//  hcount_r_flat in   NUM_CHAR*CNT_W    right column per char
//  eng_char_flat in   NUM_ENG*CHAR_W    engine results, engine e at [e*CHAR_W +: CHAR_W]
//  eng_hl_flat   out  NUM_ENG*CNT_W     window left column driven to each engine
//  eng_hr_flat   out  NUM_ENG*CNT_W     window right column driven to each engine
//  eng_en        out  NUM_ENG           engine e has a real window this frame
//  char_flat     out  NUM_CHAR*CHAR_W   collected char codes
//  char_valid    out  NUM_CHAR          slot recognised with non-empty window this pass
//  busy          out  1                 state != IDLE
//  plate_done    out  1                 1-cycle pulse, all batches collected
//  batch_idx     out  $clog2(NUM_BATCH)+1  batch currently loaded in engines
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; snapshot regs 0; vs_r resets to 1 (no spurious edge if i_vs high at release).
//  vs_pos = i_vs & ~vs_r, registered edge detect; acts in the cycle vs_pos is high.
//  States: IDLE, ARM, RUN, DONE.
//   IDLE: start & seg_valid -> snapshot all hcount_l/r into internal regs, batch_idx<=0, -> ARM. start w/o seg_valid ignored.
//   ARM : on vs_pos load batch 0 onto engines -> RUN.
//   RUN : on vs_pos: store eng_char[e] into slot batch_idx*NUM_ENG+e (slots >= NUM_CHAR discarded);
//         if batch_idx < NUM_BATCH-1: batch_idx+1, load next batch, stay RUN; else -> DONE.
//         Capture and next load occur in the same cycle (engine results latch before window changes).
//   DONE: plate_done=1 for exactly this cycle; auto_rearm ? re-snapshot (if seg_valid) -> ARM : -> IDLE.
//         If auto_rearm but !seg_valid -> IDLE.
//  Empty window: hcount_r <= hcount_l (unsigned). Engine gets eng_en=0, eng_hl/hr=0; slot stored as 0, char_valid=0.
//  Padded slot (index >= NUM_CHAR, when NUM_CHAR % NUM_ENG != 0): treated as empty.
//  Outside RUN: eng_en=0, eng_hl/hr=0.
//  char_valid/char_flat: cleared to 0 on snapshot (pass start); updated per batch; hold after DONE until next pass.
//  Latency: plate_done asserts NUM_BATCH+1 vsync rising edges after accepted start (1 arm edge + NUM_BATCH capture edges).
//  start while busy: ignored. Snapshot immune to hcount changes mid-pass.
//  abort: highest priority, any state -> IDLE next clock; eng_en=0; no plate_done; char outputs keep partial values.
//  abort & start same cycle: abort wins. vs_pos & abort same cycle: abort wins, no capture.
//  Async reset mid-pass: immediate return to reset values.
// STRUCTURE
//  Shared include lpr_defs.vh: CNT_W, CHAR_W, NUM_CHAR defaults, state encodings (IDLE=0,ARM=1,RUN=2,DONE=3).
//  One sub-module: lpr_vs_edge (vs_r register + rising/falling edge pulses), reused by other frame-synchronous blocks.
//  Batch load: combinational mux of snapshot array by batch_idx, registered onto eng_* outputs.
// TESTING
//  1 Defaults, 8 windows l=10*i+5,r=10*i+12, start -> 5 vs edges; engine models return {slot id}; plate_done on 5th edge,
//    char_valid=8'hFF, char_flat slot i = i.
//  2 Slot 3 r=l=40 -> eng_en[1]=0 during batch 1, char_valid=8'hF7, slot 3 code 0.
//  3 NUM_CHAR=7,NUM_ENG=2 -> batch 3 eng_en=2'b01, 5 edges to plate_done, char_valid=7'h7F.
//  4 Change hcount inputs after start -> eng_hl/hr still show snapshot values each batch.
//  5 abort asserted after 2nd edge -> IDLE next clock, busy=0, no plate_done, slots 0-1 retained; start ignored while busy.
//  6 auto_rearm=1, seg_valid=1 -> DONE followed by ARM, second plate_done 5 edges after first; i_vs high at reset release -> no edge.

Source files
------------

// File: rtl/lpr_char_scheduler_pkg.sv
// Shared types and defaults for the plate character scheduler slice.
// State encodings are fixed because other frame-synchronous blocks decode them.
package lpr_char_scheduler_pkg;

  localparam int DEF_NUM_CHAR = 8;
  localparam int DEF_NUM_ENG  = 2;
  localparam int DEF_CNT_W    = 12;
  localparam int DEF_CHAR_W   = 40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } schedState_e;

  function automatic int numBatch(input int numChar, input int numEng);
    return (numChar + numEng - 1) / numEng;
  endfunction

endpackage

// File: rtl/lpr_char_scheduler_if.sv
// Bundle between segmentation/engines/result path and the scheduler.
// The master side drives video, control, windows and engine results; the slave is the scheduler.
interface lpr_char_scheduler_if
  import lpr_char_scheduler_pkg::*;
#(
  parameter int NUM_CHAR = DEF_NUM_CHAR,
  parameter int NUM_ENG  = DEF_NUM_ENG,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int CHAR_W   = DEF_CHAR_W
);

  localparam int BATCH_W = $clog2(numBatch(NUM_CHAR, NUM_ENG)) + 1;

  logic                       i_vs;
  logic                       start;
  logic                       abort;
  logic                       auto_rearm;
  logic                       seg_valid;
  logic [NUM_CHAR*CNT_W-1:0]  hcount_l_flat;
  logic [NUM_CHAR*CNT_W-1:0]  hcount_r_flat;
  logic [NUM_ENG*CHAR_W-1:0]  eng_char_flat;
  logic [NUM_ENG*CNT_W-1:0]   eng_hl_flat;
  logic [NUM_ENG*CNT_W-1:0]   eng_hr_flat;
  logic [NUM_ENG-1:0]         eng_en;
  logic [NUM_CHAR*CHAR_W-1:0] char_flat;
  logic [NUM_CHAR-1:0]        char_valid;
  logic                       busy;
  logic                       plate_done;
  logic [BATCH_W-1:0]         batch_idx;

  modport master (
    output i_vs, start, abort, auto_rearm, seg_valid,
    output hcount_l_flat, hcount_r_flat, eng_char_flat,
    input  eng_hl_flat, eng_hr_flat, eng_en,
    input  char_flat, char_valid, busy, plate_done, batch_idx
  );

  modport slave (
    input  i_vs, start, abort, auto_rearm, seg_valid,
    input  hcount_l_flat, hcount_r_flat, eng_char_flat,
    output eng_hl_flat, eng_hr_flat, eng_en,
    output char_flat, char_valid, busy, plate_done, batch_idx
  );

endinterface

// File: rtl/lpr_char_scheduler_vs_edge.sv
// Vsync edge detector shared by frame-synchronous blocks.
// The history register resets high so a vsync already high at reset release is not seen as an edge.
module lpr_vs_edge (
  input  logic pixelclk,
  input  logic reset_n,
  input  logic vs_i,
  output logic vsPos_o,
  output logic vsNeg_o
);

  logic vs_q;

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q <= 1'b1;
    end else begin
      vs_q <= vs_i;
    end
  end

  assign vsPos_o = vs_i & ~vs_q;
  assign vsNeg_o = ~vs_i & vs_q;

endmodule

// File: rtl/lpr_char_scheduler.sv
// Time-multiplexes NUM_ENG recognition engines over NUM_CHAR plate slots, one batch per frame.
// Windows are snapshotted at pass start; results latch at the same vsync edge that loads the next batch.
module lpr_char_scheduler
  import lpr_char_scheduler_pkg::*;
#(
  parameter int NUM_CHAR = DEF_NUM_CHAR,
  parameter int NUM_ENG  = DEF_NUM_ENG,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int CHAR_W   = DEF_CHAR_W
) (
  input logic pixelclk,
  input logic reset_n,
  lpr_char_scheduler_if.slave bus
);

  localparam int NUM_BATCH = numBatch(NUM_CHAR, NUM_ENG);
  localparam int BATCH_W   = $clog2(NUM_BATCH) + 1;
  localparam logic [BATCH_W-1:0] LAST_BATCH = BATCH_W'(NUM_BATCH - 1);

  schedState_e                state_q;
  logic [BATCH_W-1:0]         batchIdx_q;
  logic [BATCH_W-1:0]         loadBatch;
  logic [CNT_W-1:0]           snapL_q [NUM_CHAR];
  logic [CNT_W-1:0]           snapR_q [NUM_CHAR];
  logic [NUM_ENG-1:0]         engEn_q, engEn_d;
  logic [NUM_ENG*CNT_W-1:0]   engHl_q, engHl_d;
  logic [NUM_ENG*CNT_W-1:0]   engHr_q, engHr_d;
  logic [NUM_CHAR*CHAR_W-1:0] char_q, char_d;
  logic [NUM_CHAR-1:0]        charValid_q, charValid_d;
  logic                       vsPos;
  logic                       unusedVsNeg;
  logic                       takeSnapshot;

  lpr_vs_edge uVsEdge (
    .pixelclk (pixelclk),
    .reset_n  (reset_n),
    .vs_i     (bus.i_vs),
    .vsPos_o  (vsPos),
    .vsNeg_o  (unusedVsNeg)
  );

  always_comb begin
    takeSnapshot = !bus.abort && bus.seg_valid &&
                   ((state_q == IDLE && bus.start) || (state_q == DONE && bus.auto_rearm));
  end

  // Padded slots past NUM_CHAR never match a real slot, so they load as empty windows.
  always_comb begin
    loadBatch = (state_q == RUN) ? batchIdx_q + BATCH_W'(1) : '0;
    engEn_d   = '0;
    engHl_d   = '0;
    engHr_d   = '0;
    for (int e = 0; e < NUM_ENG; e++) begin
      for (int s = 0; s < NUM_CHAR; s++) begin
        if (s == int'(loadBatch) * NUM_ENG + e && snapR_q[s] > snapL_q[s]) begin
          engEn_d[e]                  = 1'b1;
          engHl_d[e*CNT_W +: CNT_W]   = snapL_q[s];
          engHr_d[e*CNT_W +: CNT_W]   = snapR_q[s];
        end
      end
    end
  end

  always_comb begin
    char_d      = char_q;
    charValid_d = charValid_q;
    for (int s = 0; s < NUM_CHAR; s++) begin
      for (int e = 0; e < NUM_ENG; e++) begin
        if (s == int'(batchIdx_q) * NUM_ENG + e) begin
          char_d[s*CHAR_W +: CHAR_W] = engEn_q[e] ? bus.eng_char_flat[e*CHAR_W +: CHAR_W] : '0;
          charValid_d[s]             = engEn_q[e];
        end
      end
    end
  end

  // Abort outranks everything, including a simultaneous vsync capture or start.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      batchIdx_q  <= '0;
      engEn_q     <= '0;
      engHl_q     <= '0;
      engHr_q     <= '0;
      char_q      <= '0;
      charValid_q <= '0;
      for (int s = 0; s < NUM_CHAR; s++) begin
        snapL_q[s] <= '0;
        snapR_q[s] <= '0;
      end
    end else if (bus.abort) begin
      state_q <= IDLE;
      engEn_q <= '0;
      engHl_q <= '0;
      engHr_q <= '0;
    end else if (takeSnapshot) begin
      for (int s = 0; s < NUM_CHAR; s++) begin
        snapL_q[s] <= bus.hcount_l_flat[s*CNT_W +: CNT_W];
        snapR_q[s] <= bus.hcount_r_flat[s*CNT_W +: CNT_W];
      end
      char_q      <= '0;
      charValid_q <= '0;
      batchIdx_q  <= '0;
      state_q     <= ARM;
    end else begin
      case (state_q)
        ARM: begin
          if (vsPos) begin
            engEn_q <= engEn_d;
            engHl_q <= engHl_d;
            engHr_q <= engHr_d;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (vsPos) begin
            char_q      <= char_d;
            charValid_q <= charValid_d;
            if (batchIdx_q < LAST_BATCH) begin
              batchIdx_q <= loadBatch;
              engEn_q    <= engEn_d;
              engHl_q    <= engHl_d;
              engHr_q    <= engHr_d;
            end else begin
              engEn_q <= '0;
              engHl_q <= '0;
              engHr_q <= '0;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.eng_en      = engEn_q;
  assign bus.eng_hl_flat = engHl_q;
  assign bus.eng_hr_flat = engHr_q;
  assign bus.char_flat   = char_q;
  assign bus.char_valid  = charValid_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.plate_done  = (state_q == DONE);
  assign bus.batch_idx   = batchIdx_q;

endmodule

// File: tb/tb_lpr_char_scheduler.sv
// Directed bench for lpr_char_scheduler: an 8-slot and a 7-slot instance with engine models
// that report the slot number encoded in their window's left column.
module tb_lpr_char_scheduler;

  localparam int W = 320;

  logic pixelclk = 1'b0;
  logic reset_n  = 1'b0;
  logic vs       = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [95:0]  winL8, winR8;
  logic [83:0]  winL7, winR7;

  lpr_char_scheduler_if #(.NUM_CHAR(8), .NUM_ENG(2), .CNT_W(12), .CHAR_W(40)) busA ();
  lpr_char_scheduler_if #(.NUM_CHAR(7), .NUM_ENG(2), .CNT_W(12), .CHAR_W(40)) busB ();

  lpr_char_scheduler #(.NUM_CHAR(8), .NUM_ENG(2), .CNT_W(12), .CHAR_W(40)) dutA (
    .pixelclk (pixelclk),
    .reset_n  (reset_n),
    .bus      (busA.slave)
  );

  lpr_char_scheduler #(.NUM_CHAR(7), .NUM_ENG(2), .CNT_W(12), .CHAR_W(40)) dutB (
    .pixelclk (pixelclk),
    .reset_n  (reset_n),
    .bus      (busB.slave)
  );

  always #5 pixelclk = ~pixelclk;

  assign busA.i_vs = vs;
  assign busB.i_vs = vs;

  // Engines decode the slot from the window (l = 10*slot+5); idle engines present junk.
  always_comb begin
    busA.eng_char_flat = '0;
    busB.eng_char_flat = '0;
    for (int e = 0; e < 2; e++) begin
      busA.eng_char_flat[e*40 +: 40] = busA.eng_en[e] ?
        40'((busA.eng_hl_flat[e*12 +: 12] - 12'd5) / 12'd10) : 40'hDE_ADBE_EF00;
      busB.eng_char_flat[e*40 +: 40] = busB.eng_en[e] ?
        40'((busB.eng_hl_flat[e*12 +: 12] - 12'd5) / 12'd10) : 40'hDE_ADBE_EF00;
    end
  end

  task automatic tick();
    @(posedge pixelclk);
    #1;
  endtask

  task automatic edgeRise();
    vs = 1'b1;
    tick();
  endtask

  task automatic edgeFall();
    vs = 1'b0;
    tick();
  endtask

  task automatic applyStimulus(input logic [95:0] l, input logic [95:0] r);
    busA.hcount_l_flat = l;
    busA.hcount_r_flat = r;
  endtask

  task automatic pulseStartA();
    busA.start = 1'b1;
    tick();
    busA.start = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [W-1:0] expChars(input int n, input int emptySlot);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      if (i != emptySlot) v[i*40 +: 40] = 40'(i);
    end
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) begin
      winL8[i*12 +: 12] = 12'(10*i + 5);
      winR8[i*12 +: 12] = 12'(10*i + 12);
    end
    for (int i = 0; i < 7; i++) begin
      winL7[i*12 +: 12] = 12'(10*i + 5);
      winR7[i*12 +: 12] = 12'(10*i + 12);
    end
    busA.start = 1'b0; busA.abort = 1'b0; busA.auto_rearm = 1'b0; busA.seg_valid = 1'b1;
    busB.start = 1'b0; busB.abort = 1'b0; busB.auto_rearm = 1'b0; busB.seg_valid = 1'b1;
    busB.hcount_l_flat = winL7;
    busB.hcount_r_flat = winR7;
    applyStimulus(winL8, winR8);

    // Reset values, with vsync held high across release
    tick(); tick(); tick();
    checkOutput("rst_busy",  W'(busA.busy),       W'(1'b0));
    checkOutput("rst_done",  W'(busA.plate_done), W'(1'b0));
    checkOutput("rst_en",    W'(busA.eng_en),     W'(2'b00));
    checkOutput("rst_valid", W'(busA.char_valid), W'(8'h00));
    checkOutput("rst_bidx",  W'(busA.batch_idx),  W'(3'd0));
    reset_n = 1'b1;
    pulseStartA();
    checkOutput("arm_busy", W'(busA.busy), W'(1'b1));
    tick(); tick(); tick();
    checkOutput("arm_no_spurious_edge", W'(busA.eng_en), W'(2'b00));

    // Full pass; windows on the inputs are scrambled to prove the snapshot holds
    applyStimulus({8{12'h800}}, {8{12'h900}});
    edgeFall();
    edgeRise();
    checkOutput("b0_en", W'(busA.eng_en),      W'(2'b11));
    checkOutput("b0_hl", W'(busA.eng_hl_flat), W'({12'd15, 12'd5}));
    checkOutput("b0_hr", W'(busA.eng_hr_flat), W'({12'd22, 12'd12}));
    edgeFall();
    edgeRise();
    checkOutput("b1_hl",    W'(busA.eng_hl_flat), W'({12'd35, 12'd25}));
    checkOutput("b1_bidx",  W'(busA.batch_idx),   W'(3'd1));
    checkOutput("b1_valid", W'(busA.char_valid),  W'(8'h03));
    edgeFall();
    edgeRise();
    checkOutput("b2_hr",    W'(busA.eng_hr_flat), W'({12'd62, 12'd52}));
    checkOutput("b2_valid", W'(busA.char_valid),  W'(8'h0F));
    edgeFall();
    edgeRise();
    checkOutput("b3_hl",   W'(busA.eng_hl_flat), W'({12'd75, 12'd65}));
    checkOutput("b3_done", W'(busA.plate_done),  W'(1'b0));
    edgeFall();
    edgeRise();
    checkOutput("p1_done",  W'(busA.plate_done), W'(1'b1));
    checkOutput("p1_en",    W'(busA.eng_en),     W'(2'b00));
    checkOutput("p1_valid", W'(busA.char_valid), W'(8'hFF));
    checkOutput("p1_chars", busA.char_flat,      expChars(8, -1));
    edgeFall();
    checkOutput("p1_done_pulse", W'(busA.plate_done), W'(1'b0));
    checkOutput("p1_idle",       W'(busA.busy),       W'(1'b0));

    // Slot 3 empty window
    winL8[36 +: 12] = 12'd40;
    winR8[36 +: 12] = 12'd40;
    applyStimulus(winL8, winR8);
    pulseStartA();
    checkOutput("p2_clear", W'(busA.char_valid), W'(8'h00));
    edgeRise(); edgeFall();
    edgeRise();
    checkOutput("p2_b1_en", W'(busA.eng_en),      W'(2'b01));
    checkOutput("p2_b1_hl", W'(busA.eng_hl_flat), W'({12'd0, 12'd25}));
    checkOutput("p2_b1_hr", W'(busA.eng_hr_flat), W'({12'd0, 12'd32}));
    for (int k = 0; k < 3; k++) begin
      edgeFall();
      edgeRise();
    end
    checkOutput("p2_done",  W'(busA.plate_done), W'(1'b1));
    checkOutput("p2_valid", W'(busA.char_valid), W'(8'hF7));
    checkOutput("p2_chars", busA.char_flat,      expChars(8, 3));
    edgeFall();

    // Start without seg_valid, then abort after two edges
    winL8[36 +: 12] = 12'd35;
    winR8[36 +: 12] = 12'd42;
    applyStimulus(winL8, winR8);
    busA.seg_valid = 1'b0;
    pulseStartA();
    checkOutput("noseg_ignored", W'(busA.busy), W'(1'b0));
    busA.seg_valid = 1'b1;
    pulseStartA();
    edgeRise(); edgeFall();
    edgeRise(); edgeFall();
    pulseStartA();
    checkOutput("busy_start_bidx", W'(busA.batch_idx),   W'(3'd1));
    checkOutput("busy_start_hl",   W'(busA.eng_hl_flat), W'({12'd35, 12'd25}));
    busA.abort = 1'b1;
    tick();
    busA.abort = 1'b0;
    checkOutput("abort_busy",  W'(busA.busy),       W'(1'b0));
    checkOutput("abort_en",    W'(busA.eng_en),     W'(2'b00));
    checkOutput("abort_valid", W'(busA.char_valid), W'(8'h03));
    checkOutput("abort_chars", busA.char_flat,      expChars(2, -1));
    edgeRise();
    checkOutput("abort_no_done", W'(busA.plate_done), W'(1'b0));
    edgeFall();

    // Abort coinciding with a vsync edge must not capture
    pulseStartA();
    edgeRise(); edgeFall();
    vs = 1'b1;
    busA.abort = 1'b1;
    tick();
    busA.abort = 1'b0;
    checkOutput("abort_vs_valid", W'(busA.char_valid), W'(8'h00));
    checkOutput("abort_vs_busy",  W'(busA.busy),       W'(1'b0));
    edgeFall();

    // Auto re-arm: DONE goes straight to ARM, second plate_done five edges later
    busA.auto_rearm = 1'b1;
    pulseStartA();
    for (int k = 0; k < 5; k++) begin
      edgeRise();
      if (k < 4) edgeFall();
    end
    checkOutput("ar_done1", W'(busA.plate_done), W'(1'b1));
    edgeFall();
    checkOutput("ar_rearm_busy",  W'(busA.busy),       W'(1'b1));
    checkOutput("ar_rearm_valid", W'(busA.char_valid), W'(8'h00));
    for (int k = 0; k < 4; k++) begin
      edgeRise();
      edgeFall();
    end
    checkOutput("ar_not_yet", W'(busA.plate_done), W'(1'b0));
    busA.auto_rearm = 1'b0;
    edgeRise();
    checkOutput("ar_done2",  W'(busA.plate_done), W'(1'b1));
    checkOutput("ar_valid2", W'(busA.char_valid), W'(8'hFF));
    edgeFall();
    checkOutput("ar_idle", W'(busA.busy), W'(1'b0));

    // 7 slots on 2 engines: last batch has one padded engine
    busB.start = 1'b1;
    tick();
    busB.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      edgeRise();
      if (k < 3) edgeFall();
    end
    checkOutput("n7_b3_en",   W'(busB.eng_en),      W'(2'b01));
    checkOutput("n7_b3_hl",   W'(busB.eng_hl_flat), W'({12'd0, 12'd65}));
    checkOutput("n7_b3_bidx", W'(busB.batch_idx),   W'(3'd3));
    edgeFall();
    edgeRise();
    checkOutput("n7_done",  W'(busB.plate_done), W'(1'b1));
    checkOutput("n7_valid", W'(busB.char_valid), W'(7'h7F));
    checkOutput("n7_chars", busB.char_flat,      expChars(7, -1));
    edgeFall();

    // Asynchronous reset in the middle of a pass
    pulseStartA();
    edgeRise(); edgeFall();
    edgeRise(); edgeFall();
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("areset_busy",  W'(busA.busy),        W'(1'b0));
    checkOutput("areset_valid", W'(busA.char_valid),  W'(8'h00));
    checkOutput("areset_bidx",  W'(busA.batch_idx),   W'(3'd0));
    checkOutput("areset_hl",    W'(busA.eng_hl_flat), W'(24'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
